// File: rtl/ddr_mem_model.sv
// Avalon-MM slave memory model standing in for a DDR3 controller: fixed-latency
// pipelined reads, periodic waitrequest stalls, sticky error flag. Optional macro: DDR_MEM_BYTEENABLE_EN.
module ddr_mem_model #(
    parameter int DATA_W       = 16,
    parameter int ADDR_W       = 32,
    parameter int DEPTH        = 256,
    parameter int RD_LATENCY   = 2,
    parameter int STALL_PERIOD = 64,
    parameter int STALL_CYCLES = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] ddr_addr,
    input  logic              ddr_read,
    input  logic              ddr_write,
    input  logic [DATA_W-1:0] ddr_writedata,
`ifdef DDR_MEM_BYTEENABLE_EN
    input  logic [DATA_W/8-1:0] ddr_byteenable,
`endif
    output logic [DATA_W-1:0] ddr_readdata,
    output logic              ddr_readdatavalid,
    output logic              ddr_waitrequest,
    output logic              ddr_err,
    output logic              dbg_state
);

    localparam int BYTES = DATA_W / 8;
    localparam int SHIFT = $clog2(BYTES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_STALL = 1'b1
    } state_e;

    // Handshake: a command is taken at a rising edge where exactly one of
    // read/write is high and waitrequest is low; while waitrequest is high the
    // master holds its signals and nothing is sampled.
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] word_idx;
    logic [IDX_W-1:0]  mem_idx;
    logic              in_range, cmd_ok, conflict, rd_acc, wr_acc;
    logic [DATA_W-1:0] rd_word, wr_word;

    assign word_idx = ddr_addr >> SHIFT;
    assign mem_idx  = word_idx[IDX_W-1:0];
    assign in_range = word_idx < ADDR_W'(DEPTH);
    assign cmd_ok   = !ddr_waitrequest;
    assign conflict = ddr_read & ddr_write & cmd_ok;
    assign rd_acc   = ddr_read & !ddr_write & cmd_ok;
    assign wr_acc   = ddr_write & !ddr_read & cmd_ok;
    assign rd_word  = in_range ? mem_q[mem_idx] : '0;

    always_comb begin
`ifdef DDR_MEM_BYTEENABLE_EN
        wr_word = mem_q[mem_idx];
        for (int b = 0; b < BYTES; b++) begin
            if (ddr_byteenable[b]) wr_word[b*8 +: 8] = ddr_writedata[b*8 +: 8];
        end
`else
        wr_word = ddr_writedata;
`endif
    end

    // Storage has no reset so contents survive a reset pulse.
    always_ff @(posedge clk) begin
        if (wr_acc && in_range) mem_q[mem_idx] <= wr_word;
    end

    logic [RD_LATENCY-1:0] vld_q, vld_d;
    logic [DATA_W-1:0]     data_q [RD_LATENCY];
    logic [DATA_W-1:0]     data_d [RD_LATENCY];

    always_comb begin
        vld_d[0]  = rd_acc;
        data_d[0] = rd_word;
        for (int i = 1; i < RD_LATENCY; i++) begin
            vld_d[i]  = vld_q[i-1];
            data_d[i] = data_q[i-1];
        end
        // The last stage is the readdata output and holds when nothing arrives.
        if (!vld_d[RD_LATENCY-1]) data_d[RD_LATENCY-1] = data_q[RD_LATENCY-1];
    end

    assign ddr_readdata      = data_q[RD_LATENCY-1];
    assign ddr_readdatavalid = vld_q[RD_LATENCY-1];

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cmd_cnt_q, cmd_cnt_d;
    logic [7:0]       stall_cnt_q, stall_cnt_d;
    logic             wait_q, wait_d, err_q, err_d;

    always_comb begin
        state_d     = state_q;
        cmd_cnt_d   = cmd_cnt_q;
        stall_cnt_d = stall_cnt_q;
        wait_d      = wait_q;
        err_d       = err_q | conflict | ((rd_acc | wr_acc) & !in_range);
        case (state_q)
            ST_IDLE: begin
                if ((rd_acc || wr_acc) && STALL_PERIOD != 0) begin
                    if (cmd_cnt_q == CNT_W'(STALL_PERIOD - 1)) begin
                        cmd_cnt_d   = '0;
                        stall_cnt_d = 8'(STALL_CYCLES);
                        state_d     = ST_STALL;
                        wait_d      = 1'b1;
                    end else begin
                        cmd_cnt_d = cmd_cnt_q + 1'b1;
                    end
                end
            end
            ST_STALL: begin
                stall_cnt_d = stall_cnt_q - 8'd1;
                if (stall_cnt_q == 8'd1) begin
                    state_d = ST_IDLE;
                    wait_d  = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cmd_cnt_q   <= '0;
            stall_cnt_q <= '0;
            wait_q      <= 1'b0;
            err_q       <= 1'b0;
            vld_q       <= '0;
            for (int i = 0; i < RD_LATENCY; i++) data_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            cmd_cnt_q   <= cmd_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            wait_q      <= wait_d;
            err_q       <= err_d;
            vld_q       <= vld_d;
            for (int i = 0; i < RD_LATENCY; i++) data_q[i] <= data_d[i];
        end
    end

    assign ddr_waitrequest = wait_q;
    assign ddr_err         = err_q;
    assign dbg_state       = state_q;

endmodule

// File: doc/ddr_mem_model.md
Name: ddr_mem_model

Overview:
Parametrised behavioural/synthesisable Avalon-MM slave memory model standing in for the DDR3 controller in Avalon master testbenches. Word-addressed storage behind a byte-addressed bus, pipelined reads with fixed configurable latency, and deterministic periodic waitrequest back-pressure. Protocol violations and out-of-range accesses are flagged. Used under avalon_mm_master benches in place of the real controller.

Parameters:
DATA_W, 16, data width in bits; multiple of 8, power-of-two byte count
ADDR_W, 32, byte-address width
DEPTH, 256, number of DATA_W words stored
RD_LATENCY, 2, cycles from read acceptance edge to readdatavalid; legal 1..8
STALL_PERIOD, 64, accepted commands between stall bursts; 0 disables stalls
STALL_CYCLES, 5, waitrequest-high cycles per stall burst; legal 1..255

Ports:
clk  in  1  clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
ddr_addr  in  ADDR_W  byte address
ddr_read  in  1  read request
ddr_write  in  1  write request
ddr_writedata  in  DATA_W  write data
ddr_readdata  out  DATA_W  read data, registered
ddr_readdatavalid  out  1  one-cycle strobe per accepted read
ddr_waitrequest  out  1  registered back-pressure
ddr_err  out  1  sticky error flag

Behaviour:
- Reset (reset_n=0 at edge): readdata=0, readdatavalid=0, waitrequest=0, err=0; read pipeline flushed (pending reads discarded, never returned); command and stall counters cleared; memory contents retained.
- Word index = ddr_addr >> log2(DATA_W/8); low address bits ignored. In range iff index < DEPTH.
- Command accepted at edge where (read XOR write) && !ddr_waitrequest. Master holds signals while waitrequest=1; nothing is sampled then.
- read && write same cycle: no access, not counted, err set; waitrequest unaffected.
- Write accepted: mem[index] <= writedata if in range; else dropped, err set.
- Read accepted: mem[index] (or 0 if out of range, err set) enters RD_LATENCY-stage valid/data shift pipeline; readdatavalid high exactly RD_LATENCY cycles after acceptance edge, one cycle, data on readdata same cycle. readdata holds last value when valid low.
- Full throughput: one read per cycle, returns in order, no bubbles.
- Read accepted the cycle after a write to same index returns new data; read-during-write impossible (one command per cycle).
- Stall FSM: IDLE/STALL. cmd_cnt counts accepted commands; on acceptance with cmd_cnt==STALL_PERIOD-1 -> cmd_cnt=0, stall_cnt=STALL_CYCLES, go STALL. STALL: waitrequest=1, decrement each cycle; return to IDLE when reaching 0 (waitrequest high exactly STALL_CYCLES cycles, starting the cycle after the Nth acceptance). Read pipeline keeps draining during STALL.
- STALL_PERIOD=0: FSM stays IDLE, waitrequest constantly 0.
- err cleared only by reset.

Optional Feature:
DDR_MEM_BYTEENABLE_EN: adds input ddr_byteenable, width DATA_W/8; accepted write updates only bytes whose enable bit is 1; all-zero enable is a no-op write that still counts toward STALL_PERIOD; reads ignore it. Undefined: port absent, every write updates the full word.

Test Plan:
Write addr 0x4 data 0x1234, then read addr 0x4 -> readdatavalid exactly 2 cycles after read acceptance, readdata=0x1234, err=0.
Read addrs 0x0,0x2,0x4 back-to-back after writing 0xA,0xB,0xC -> three consecutive valid cycles returning 0x000A,0x000B,0x000C in order.
64 consecutive accepted writes -> waitrequest high cycles 1..5 after 64th acceptance, low on 6th; 65th write accepted only then.
Write addr 0x200 (index 256) data 0xFFFF -> memory unchanged, err=1; read 0x200 -> valid with readdata=0x0000.
read=write=1 at addr 0x0 -> no valid strobe, mem[0] unchanged, err=1, cmd_cnt unchanged.
Reset asserted 1 cycle after read acceptance -> no readdatavalid afterward; outputs 0; earlier-written data still readable after reset; with DDR_MEM_BYTEENABLE_EN, write 0xBEEF enable 2'b01 over 0x1234 -> reads 0x12EF.
